// File: rtl/instr_sequencer.sv
// Purpose : instruction-issue front end for simple_cpu; a program store plus a PC that
//           presents each word on instruction_o for exactly the cycles the CU consumes it.
// Latency : start -> PRIME next edge -> first word one edge later; std_op held 3 cycles,
//           loadR/storeR held 4, first word +1; consecutive words are issued with no bubble.
// Backpressure: none; issue is open-loop, timed by the hold counter. start/prog_we are
//           ignored while busy, start is ignored in DONE, and only reset leaves DONE.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset (program store is not cleared)
//   start_i        1-cycle pulse, begin issuing from address 0 (IDLE only)
//   prog_we_i      program store write enable (honoured in IDLE/DONE only)
//   prog_addr_i    program store write address
//   prog_data_i    program store write data
//   instruction_o  registered instruction to the CU, 0 when not issuing
//   pc_o           address of the instruction currently presented
//   busy_o         1 in PRIME/ISSUE
//   done_o         1 in DONE, sticky until reset
//   retired_o      (RETIRE_COUNT_EN only) count of words that completed their hold
//
// Optional feature macro: RETIRE_COUNT_EN adds the retired_o counter.

module instr_sequencer #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   prog_we_i,
    input  logic [PC_BITS-1:0]     prog_addr_i,
    input  logic [INSTR_WIDTH-1:0] prog_data_i,
    output logic [INSTR_WIDTH-1:0] instruction_o,
    output logic [PC_BITS-1:0]     pc_o,
    output logic                   busy_o,
    output logic                   done_o
`ifdef RETIRE_COUNT_EN
    ,
    output logic [PC_BITS:0]       retired_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [PC_BITS-1:0] PC_LAST = '1;

    // Cycles a word of the given class stays on the CU input; class 00 is HALT.
    function automatic logic [2:0] hold_len(input logic [1:0] cls);
        case (cls)
            2'b01:   hold_len = 3'd3;
            2'b10:   hold_len = 3'd4;
            2'b11:   hold_len = 3'd4;
            default: hold_len = 3'd0;
        endcase
    endfunction

    logic [INSTR_WIDTH-1:0] mem_q [2**PC_BITS];

    state_e                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_BITS-1:0]     pc_q, pc_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [PC_BITS-1:0]     pc_inc;
    logic [INSTR_WIDTH-1:0] cur_word;
    logic [INSTR_WIDTH-1:0] nxt_word;
    logic [1:0]             cur_cls;
    logic [1:0]             nxt_cls;
    logic                   mem_we;

    assign pc_inc   = pc_q + PC_BITS'(1);
    assign cur_word = mem_q[pc_q];
    // Only meaningful when pc_q is not the last address; the wrap is never used.
    assign nxt_word = mem_q[pc_inc];
    assign cur_cls  = cur_word[INSTR_WIDTH-1 -: 2];
    assign nxt_cls  = nxt_word[INSTR_WIDTH-1 -: 2];

    // The store is frozen while a program runs so the sequence cannot change under us.
    assign mem_we = prog_we_i && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[prog_addr_i] <= prog_data_i;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                // A simultaneous store write takes priority over start.
                if (start_i && !prog_we_i) begin
                    state_d = S_PRIME;
                    pc_d    = '0;
                end
            end
            S_PRIME: begin
                if (cur_cls == 2'b00) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ISSUE;
                    instr_d = cur_word;
                    // Extra cycle covers the CU leaving its RESET state.
                    cnt_d   = hold_len(cur_cls) + 3'd1;
                end
            end
            S_ISSUE: begin
                if (cnt_q == 3'd1) begin
                    if (pc_q == PC_LAST) begin
                        state_d = S_DONE;
                        instr_d = '0;
                        cnt_d   = '0;
                    end else if (nxt_cls == 2'b00) begin
                        state_d = S_DONE;
                        instr_d = '0;
                        pc_d    = pc_inc;
                        cnt_d   = '0;
                    end else begin
                        instr_d = nxt_word;
                        pc_d    = pc_inc;
                        cnt_d   = hold_len(nxt_cls);
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they flip on the entry edge.
    assign busy_d = (state_d == S_PRIME) || (state_d == S_ISSUE);
    assign done_d = (state_d == S_DONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign instruction_o = instr_q;
    assign pc_o          = pc_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

`ifdef RETIRE_COUNT_EN
    logic [PC_BITS:0] retired_q;
    logic             retire;

    // A word retires on the last cycle of its hold.
    assign retire = (state_q == S_ISSUE) && (cnt_q == 3'd1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + (PC_BITS+1)'(1);
        end
    end

    assign retired_o = retired_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

    localparam logic [19:0] W_STD = 20'h51000;
    localparam logic [19:0] W_LD  = 20'h94050;

    logic        clk_i;
    logic        rst_ni;
    logic        start_i;
    logic        prog_we_i;
    logic [4:0]  prog_addr_i;
    logic [19:0] prog_data_i;
    logic [19:0] instruction_o;
    logic [4:0]  pc_o;
    logic        busy_o;
    logic        done_o;
`ifdef RETIRE_COUNT_EN
    logic [5:0]  retired_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [19:0] tr_instr[$];
    logic [4:0]  tr_pc[$];
    int          tr_busy;
    int          tr_overlap;

    instr_sequencer #(.INSTR_WIDTH(20), .PC_BITS(5)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .prog_we_i     (prog_we_i),
        .prog_addr_i   (prog_addr_i),
        .prog_data_i   (prog_data_i),
        .instruction_o (instruction_o),
        .pc_o          (pc_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
`ifdef RETIRE_COUNT_EN
        ,
        .retired_o     (retired_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_ni    = 1'b0;
        start_i   = 1'b0;
        prog_we_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic write_mem(input logic [4:0] addr, input logic [19:0] data);
        prog_we_i   = 1'b1;
        prog_addr_i = addr;
        prog_data_i = data;
        @(negedge clk_i);
        prog_we_i   = 1'b0;
    endtask

    function automatic int count_of(input logic [19:0] v);
        int n = 0;
        foreach (tr_instr[i]) if (tr_instr[i] == v) n++;
        return n;
    endfunction

    function automatic int first_idx(input logic [19:0] v);
        foreach (tr_instr[i]) if (tr_instr[i] == v) return i;
        return -1;
    endfunction

    // Pulse start, then record one sample per cycle (index 0 = PRIME) until done.
    // At index dis_idx a store write to addr 1 and a second start are driven.
    task automatic run_trace(input string tag, input int dis_idx);
        tr_instr.delete();
        tr_pc.delete();
        tr_busy    = 0;
        tr_overlap = 0;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tr_instr.push_back(instruction_o);
            tr_pc.push_back(pc_o);
            if (busy_o) tr_busy++;
            if (busy_o && done_o) tr_overlap++;
            if (done_o) break;
            if (i == dis_idx) begin
                prog_we_i   = 1'b1;
                prog_addr_i = 5'd1;
                prog_data_i = 20'h0;
                start_i     = 1'b1;
            end else begin
                prog_we_i = 1'b0;
                start_i   = 1'b0;
            end
            @(negedge clk_i);
        end
        prog_we_i = 1'b0;
        start_i   = 1'b0;
        check_val({tag, "_done"}, 32'(done_o), 32'd1);
        check_val({tag, "_no_overlap"}, 32'(tr_overlap), 32'd0);
    endtask

    initial begin
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        prog_we_i   = 1'b0;
        prog_addr_i = '0;
        prog_data_i = '0;

        // Reset state
        do_reset();
        check_val("rst_instr", 32'(instruction_o), 32'h0);
        check_val("rst_pc", 32'(pc_o), 32'd0);
        check_val("rst_busy", 32'(busy_o), 32'd0);
        check_val("rst_done", 32'(done_o), 32'd0);

        // Test 1: single std_op then HALT
        write_mem(5'd0, W_STD);
        write_mem(5'd1, 20'h0);
        // start together with a write is ignored
        prog_we_i = 1'b1; prog_addr_i = 5'd5; prog_data_i = W_STD; start_i = 1'b1;
        @(negedge clk_i);
        prog_we_i = 1'b0; start_i = 1'b0;
        @(negedge clk_i);
        check_val("t1_start_with_we_busy", 32'(busy_o), 32'd0);
        run_trace("t1", -1);
        check_val("t1_len", 32'(tr_instr.size()), 32'd6);
        check_val("t1_prime_instr", 32'(tr_instr[0]), 32'h0);
        check_val("t1_hold", 32'(count_of(W_STD)), 32'd4);
        check_val("t1_first", 32'(first_idx(W_STD)), 32'd1);
        check_val("t1_busy_cycles", 32'(tr_busy), 32'd5);
        check_val("t1_pc", 32'(pc_o), 32'd1);
        check_val("t1_instr_end", 32'(instruction_o), 32'h0);

        // Test 2: std_op + loadR back-to-back
        do_reset();
        write_mem(5'd0, W_STD);
        write_mem(5'd1, W_LD);
        write_mem(5'd2, 20'h0);
        run_trace("t2", -1);
        check_val("t2_len", 32'(tr_instr.size()), 32'd10);
        check_val("t2_w0_hold", 32'(count_of(W_STD)), 32'd4);
        check_val("t2_w1_hold", 32'(count_of(W_LD)), 32'd4);
        check_val("t2_w1_first", 32'(first_idx(W_LD)), 32'd5);
        check_val("t2_pc", 32'(pc_o), 32'd2);
        check_val("t2_busy", 32'(busy_o), 32'd0);
`ifdef RETIRE_COUNT_EN
        check_val("t2_retired", 32'(retired_o), 32'd2);
`endif

        // Test 3: HALT at address 0
        do_reset();
        write_mem(5'd0, 20'h0);
        run_trace("t3", -1);
        check_val("t3_len", 32'(tr_instr.size()), 32'd2);
        check_val("t3_busy_cycles", 32'(tr_busy), 32'd1);
        check_val("t3_instr0", 32'(tr_instr[0]), 32'h0);
        check_val("t3_instr_end", 32'(instruction_o), 32'h0);
        check_val("t3_pc", 32'(pc_o), 32'd0);

        // Test 4: full store, no wrap
        do_reset();
        for (int a = 0; a < 32; a++) write_mem(5'(a), W_STD);
        run_trace("t4", -1);
        check_val("t4_len", 32'(tr_instr.size()), 32'd99);
        check_val("t4_hold_total", 32'(count_of(W_STD)), 32'd97);
        check_val("t4_busy_cycles", 32'(tr_busy), 32'd98);
        check_val("t4_pc_idx1", 32'(tr_pc[1]), 32'd0);
        check_val("t4_pc_idx5", 32'(tr_pc[5]), 32'd1);
        check_val("t4_pc_idx8", 32'(tr_pc[8]), 32'd2);
        check_val("t4_pc_idx97", 32'(tr_pc[97]), 32'd31);
        check_val("t4_pc_end", 32'(pc_o), 32'd31);
        check_val("t4_instr_end", 32'(instruction_o), 32'h0);

        // Test 5: async reset mid-hold of pc=2
        do_reset();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (pc_o == 5'd2) break;
            @(negedge clk_i);
        end
        check_val("t5_pc2_reached", 32'(pc_o), 32'd2);
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check_val("t5_rst_instr", 32'(instruction_o), 32'h0);
        check_val("t5_rst_busy", 32'(busy_o), 32'd0);
        check_val("t5_rst_pc", 32'(pc_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        run_trace("t5", -1);
        check_val("t5_store_intact", 32'(count_of(W_STD)), 32'd97);

        // Test 6: write and start while busy are ignored
        do_reset();
        write_mem(5'd0, W_STD);
        write_mem(5'd1, W_LD);
        write_mem(5'd2, 20'h0);
        run_trace("t6", 2);
        check_val("t6_len", 32'(tr_instr.size()), 32'd10);
        check_val("t6_w1_hold", 32'(count_of(W_LD)), 32'd4);
        // start in DONE is ignored
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        check_val("t6_done_sticky", 32'(done_o), 32'd1);
        check_val("t6_done_busy", 32'(busy_o), 32'd0);
        check_val("t6_done_pc", 32'(pc_o), 32'd2);
        do_reset();
        run_trace("t6b", -1);
        check_val("t6_mem1_intact", 32'(count_of(W_LD)), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
